// File: rtl/mdsa_pkg.sv
// Shared types and defaults for the MDSA sorter job arbiter.
package mdsa_pkg;

    localparam int MDSA_FRAME_W     = 72;
    localparam int MDSA_TIMEOUT_DEF = 128;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LAUNCH   = 3'd1,
        WAIT_ACK = 3'd2,
        RUN      = 3'd3,
        RESP     = 3'd4
    } mdsa_arb_state_t;

endpackage

// File: rtl/mdsa_rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr, searching cyclically.
module mdsa_rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt_oh,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any_req
);

    logic             found_hi;
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;

    // Descending scan leaves the lowest matching index in each candidate.
    always_comb begin
        found_hi = 1'b0;
        any_req  = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && (IDX_W'(i) >= ptr)) begin
                hi_idx   = IDX_W'(i);
                found_hi = 1'b1;
            end
            if (req[i]) begin
                lo_idx  = IDX_W'(i);
                any_req = 1'b1;
            end
        end
        gnt_idx = found_hi ? hi_idx : lo_idx;
        gnt_oh  = any_req ? (NUM_REQ'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/mdsa_job_arbiter.sv
// Shares one MDSA bitonic sorter among NUM_REQ requesters, one frame at a time, with a
// watchdog that turns a hung job into an error response.
//   state    | meaning
//   IDLE     | arbitrate; accept a frame when the sorter reports ready
//   LAUNCH   | single-cycle sorter_start, watchdog cleared
//   WAIT_ACK | wait for the sorter to leave READY
//   RUN      | wait for sorter_oe or watchdog expiry
//   RESP     | hold the response until rsp_ready
module mdsa_job_arbiter
    import mdsa_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int FRAME_W     = MDSA_FRAME_W,
    parameter  int TIMEOUT_CYC = MDSA_TIMEOUT_DEF,
    localparam int IDX_W       = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*FRAME_W-1:0] req_data,
    output logic                       sorter_start,
    output logic [FRAME_W-1:0]         sorter_frame,
    input  logic                       sorter_ready,
    input  logic                       sorter_oe,
    input  logic [FRAME_W-1:0]         sorter_result,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [IDX_W-1:0]           rsp_id,
    output logic [FRAME_W-1:0]         rsp_data,
    output logic                       rsp_err,
    output logic                       busy
);

    localparam int               WD_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    mdsa_arb_state_t    state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   job_id_q, job_id_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               sorter_start_q, sorter_start_d;
    logic [FRAME_W-1:0] sorter_frame_q, sorter_frame_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [IDX_W-1:0]   rsp_id_q, rsp_id_d;
    logic [FRAME_W-1:0] rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;

    logic [NUM_REQ-1:0] gnt_oh;
    logic [IDX_W-1:0]   gnt_idx;
    logic               any_req;
    logic [WD_W-1:0]    wd_inc;
    logic               timeout;
    logic [FRAME_W-1:0] req_frame [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_frame
        assign req_frame[i] = req_data[i*FRAME_W +: FRAME_W];
    end

    mdsa_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt_oh  (gnt_oh),
        .gnt_idx (gnt_idx),
        .any_req (any_req)
    );

    // rst also gates req_ready so no accept is visible while reset is held.
    assign req_ready    = (state_q == IDLE && sorter_ready && rst) ? gnt_oh : '0;
    assign busy         = (state_q != IDLE);
    assign sorter_start = sorter_start_q;
    assign sorter_frame = sorter_frame_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_err      = rsp_err_q;

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        job_id_d       = job_id_q;
        wd_d           = wd_q;
        sorter_start_d = 1'b0;
        sorter_frame_d = sorter_frame_q;
        rsp_id_d       = rsp_id_q;
        rsp_data_d     = rsp_data_q;
        rsp_err_d      = rsp_err_q;
        wd_inc         = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
        // Counting the current cycle, the watchdog reaches TIMEOUT_CYC here.
        timeout        = (wd_q >= WD_LAST);

        case (state_q)
            IDLE: begin
                if (any_req && sorter_ready) begin
                    sorter_frame_d = req_frame[gnt_idx];
                    job_id_d       = gnt_idx;
                    sorter_start_d = 1'b1;
                    state_d        = LAUNCH;
                end
            end
            LAUNCH: begin
                wd_d    = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                wd_d = wd_inc;
                if (timeout) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    rsp_id_d   = job_id_q;
                    state_d    = RESP;
                end else if (!sorter_ready) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                wd_d = wd_inc;
                if (sorter_oe) begin
                    rsp_data_d = sorter_result;
                    rsp_err_d  = 1'b0;
                    rsp_id_d   = job_id_q;
                    state_d    = RESP;
                end else if (timeout) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    rsp_id_d   = job_id_q;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rr_ptr_d = (job_id_q == IDX_LAST) ? '0 : job_id_q + 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            rr_ptr_q       <= '0;
            job_id_q       <= '0;
            wd_q           <= '0;
            sorter_start_q <= 1'b0;
            sorter_frame_q <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_id_q       <= '0;
            rsp_data_q     <= '0;
            rsp_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            job_id_q       <= job_id_d;
            wd_q           <= wd_d;
            sorter_start_q <= sorter_start_d;
            sorter_frame_q <= sorter_frame_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_id_q       <= rsp_id_d;
            rsp_data_q     <= rsp_data_d;
            rsp_err_q      <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_mdsa_job_arbiter.sv
// Directed bench: instance 0 uses the default 128-cycle watchdog, instance 1 a 16-cycle one.
module tb_mdsa_job_arbiter;

    localparam int NR = 4;
    localparam int FW = 72;

    logic clk;
    logic rst;

    logic [NR-1:0]    req_valid [2];
    logic [NR-1:0]    req_ready [2];
    logic [NR*FW-1:0] req_data  [2];
    logic             s_start   [2];
    logic [FW-1:0]    s_frame   [2];
    logic             s_ready   [2];
    logic             s_oe      [2];
    logic [FW-1:0]    s_result  [2];
    logic             rsp_valid [2];
    logic             rsp_ready [2];
    logic [1:0]       rsp_id    [2];
    logic [FW-1:0]    rsp_data  [2];
    logic             rsp_err   [2];
    logic             busy      [2];

    int n_chk  = 0;
    int n_fail = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mdsa_job_arbiter #(
            .NUM_REQ     (NR),
            .FRAME_W     (FW),
            .TIMEOUT_CYC ((g == 0) ? 128 : 16)
        ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .req_valid     (req_valid[g]),
            .req_ready     (req_ready[g]),
            .req_data      (req_data[g]),
            .sorter_start  (s_start[g]),
            .sorter_frame  (s_frame[g]),
            .sorter_ready  (s_ready[g]),
            .sorter_oe     (s_oe[g]),
            .sorter_result (s_result[g]),
            .rsp_valid     (rsp_valid[g]),
            .rsp_ready     (rsp_ready[g]),
            .rsp_id        (rsp_id[g]),
            .rsp_data      (rsp_data[g]),
            .rsp_err       (rsp_err[g]),
            .busy          (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [FW-1:0] frame_of(input int i);
        case (i)
            0:       return 72'h11_22_33_44_55_66_77_88_99;
            1:       return 72'hA0_A1_A2_A3_A4_A5_A6_A7_A8;
            2:       return 72'h09_08_07_06_05_04_03_02_01;
            default: return 72'h3C_C3_5A_A5_0F_F0_69_96_E1;
        endcase
    endfunction

    task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives one complete job on instance d; the sorter model answers lat cycles after start,
    // or never when hang is set. bp is the number of cycles rsp_ready is held low.
    task automatic run_job(input int d, input logic [NR-1:0] valid, input int exp_id,
                           input int lat, input bit hang, input logic [FW-1:0] res, input int bp);
        int n;
        logic [FW-1:0] exp_data;
        exp_data = hang ? '0 : res;
        @(negedge clk);
        req_valid[d] = valid;
        #1;
        n = 0;
        while (req_ready[d] == '0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("grant", FW'(req_ready[d]), FW'(4'b0001 << exp_id));
        @(negedge clk);
        req_valid[d] = '0;
        check("start_pulse", FW'(s_start[d]), 1);
        check("sorter_frame", s_frame[d], frame_of(exp_id));
        s_ready[d] = 1'b0;
        @(negedge clk);
        check("start_low", FW'(s_start[d]), 0);
        repeat (lat - 1) @(negedge clk);
        check("no_rsp_early", FW'(rsp_valid[d]), 0);
        check("frame_held", s_frame[d], frame_of(exp_id));
        if (!hang) begin
            s_oe[d]     = 1'b1;
            s_result[d] = res;
        end
        @(negedge clk);
        s_oe[d]     = 1'b0;
        s_result[d] = '0;
        s_ready[d]  = 1'b1;
        check("rsp_valid", FW'(rsp_valid[d]), 1);
        check("rsp_id", FW'(rsp_id[d]), FW'(exp_id));
        check("rsp_data", rsp_data[d], exp_data);
        check("rsp_err", FW'(rsp_err[d]), FW'(hang));
        req_valid[d] = 4'b1111;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check("bp_valid", FW'(rsp_valid[d]), 1);
            check("bp_id", FW'(rsp_id[d]), FW'(exp_id));
            check("bp_data", rsp_data[d], exp_data);
            check("bp_no_ready", FW'(req_ready[d]), 0);
        end
        req_valid[d] = '0;
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        check("rsp_retired", FW'(rsp_valid[d]), 0);
        check("idle_after", FW'(busy[d]), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = '0;
            req_data[d]  = {frame_of(3), frame_of(2), frame_of(1), frame_of(0)};
            s_ready[d]   = 1'b1;
            s_oe[d]      = 1'b0;
            s_result[d]  = '0;
            rsp_ready[d] = 1'b0;
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_busy", FW'(busy[d]), 0);
            check("rst_rsp_valid", FW'(rsp_valid[d]), 0);
            check("rst_start", FW'(s_start[d]), 0);
            check("rst_frame", s_frame[d], 0);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Sorter not ready: requests must not be granted.
        @(negedge clk);
        s_ready[0]   = 1'b0;
        req_valid[0] = 4'b1111;
        #1;
        check("nordy_grant", FW'(req_ready[0]), 0);
        repeat (3) @(negedge clk);
        check("nordy_grant_late", FW'(req_ready[0]), 0);
        check("nordy_busy", FW'(busy[0]), 0);
        req_valid[0] = '0;
        s_ready[0]   = 1'b1;

        // Single job from requester 2, sorter answers 54 cycles after start.
        run_job(0, 4'b0100, 2, 54, 1'b0, 72'h01_02_03_04_05_06_07_08_09, 0);

        // Reset asynchronously while the next job (requester 1) is running.
        @(negedge clk);
        req_valid[0] = 4'b0010;
        #1;
        check("pre_rst_grant", FW'(req_ready[0]), FW'(4'b0010));
        @(negedge clk);
        req_valid[0] = '0;
        s_ready[0]   = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_busy", FW'(busy[0]), 1);
        req_valid[0] = 4'b1111;
        s_ready[0]   = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("mid_rst_ready", FW'(req_ready[0]), 0);
        check("mid_rst_busy", FW'(busy[0]), 0);
        check("mid_rst_start", FW'(s_start[0]), 0);
        check("mid_rst_frame", s_frame[0], 0);
        check("mid_rst_valid", FW'(rsp_valid[0]), 0);
        check("mid_rst_id", FW'(rsp_id[0]), 0);
        check("mid_rst_data", rsp_data[0], 0);
        check("mid_rst_err", FW'(rsp_err[0]), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("post_rst_grant", FW'(req_ready[0]), FW'(4'b0001));
        req_valid[0] = '0;
        repeat (3) @(negedge clk);
        check("dropped_no_rsp", FW'(rsp_valid[0]), 0);
        check("post_rst_idle", FW'(busy[0]), 0);

        // Round-robin: all requesters valid for eight jobs.
        for (int j = 0; j < 8; j++) begin
            run_job(0, 4'b1111, j % 4, 5, 1'b0, {8'(j), 64'hFEDC_BA98_7654_3210}, 0);
        end

        // Response backpressure for 10 cycles.
        run_job(0, 4'b1000, 3, 6, 1'b0, 72'hDE_AD_BE_EF_01_23_45_67_89, 10);

        // Short watchdog instance: normal job, hung job, then sorter_oe on the final cycle.
        run_job(1, 4'b0001, 0, 5, 1'b0, 72'hA5_A5_A5_A5_A5_A5_A5_A5_A5, 0);
        run_job(1, 4'b0010, 1, 16, 1'b1, 72'h0, 0);
        run_job(1, 4'b0100, 2, 16, 1'b0, 72'h5A_5A_5A_5A_5A_5A_5A_5A_5A, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
